mix_pipe_acc: RTL and testbench

- Parametrised, pipelined successor to the team's combinational mixing datapaths.
- Takes an IN_W-bit operand and runs a fixed add/complement/multiply/xor mixing chain over three registered stages, producing an OUT_W-bit result.
- Adds valid/ready flow control with per-stage backpressure, a selectable final-stage mode, an optional running XOR accumulator across transactions, and a transaction counter.
- Sits between a stimulus source and a result sink in the generated-datapath test fabric.

---
 rtl/mix_pipe_pkg.sv | 63 ++++++
 rtl/mix_pipe_acc_pipe_stage_reg.sv | 45 ++++
 rtl/mix_pipe_acc.sv | 121 ++++++++++++
 tb/tb_mix_pipe_acc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pipe_pkg.sv
// Shared types and mixing functions for the mix_pipe_acc datapath.
// Functions work on 64-bit carriers and mask to the requested width.
package mix_pipe_pkg;

  localparam int unsigned DW_MAX = 64;

  typedef enum logic {
    MODE_SHR    = 1'b0,
    MODE_ROTADD = 1'b1
  } mode_e;

  // Widest form of a stage payload; the top narrows data to OUT_W.
  typedef struct packed {
    logic [DW_MAX-1:0] data;
    mode_e             mode;
    logic              acc_en;
  } stage_pl_t;

  function automatic logic [DW_MAX-1:0] width_mask(input int unsigned w);
    if (w >= DW_MAX) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // t0 = a + nx + a, with nx the in_w-bit complement of x
  function automatic logic [DW_MAX-1:0] mix_s1(input logic [DW_MAX-1:0] x,
                                               input int unsigned in_w,
                                               input int unsigned out_w);
    logic [DW_MAX-1:0] a;
    logic [DW_MAX-1:0] nx;
    a  = x & width_mask(in_w);
    nx = ~x & width_mask(in_w);
    return (a + nx + a) & width_mask(out_w);
  endfunction

  // t1 = (t0 * ~t0) ^ t0, complement and product both out_w wide
  function automatic logic [DW_MAX-1:0] mix_s2(input logic [DW_MAX-1:0] t0,
                                               input int unsigned out_w);
    logic [DW_MAX-1:0] m;
    logic [DW_MAX-1:0] nt;
    m  = width_mask(out_w);
    nt = ~t0 & m;
    return ((t0 * nt) ^ t0) & m;
  endfunction

  // t2 = rotate-add or xor-shift depending on mode
  function automatic logic [DW_MAX-1:0] mix_s3(input logic [DW_MAX-1:0] t1,
                                               input mode_e mode,
                                               input int unsigned out_w,
                                               input int unsigned shift,
                                               input int unsigned rot);
    logic [DW_MAX-1:0] m;
    logic [DW_MAX-1:0] v;
    logic [DW_MAX-1:0] r;
    m = width_mask(out_w);
    v = t1 & m;
    if (mode == MODE_ROTADD) begin
      r = ((v << rot) | (v >> (out_w - rot))) & m;
      return (v + r) & m;
    end
    return (v ^ (v >> shift)) & m;
  endfunction

endpackage

// File: rtl/mix_pipe_acc_pipe_stage_reg.sv
// Valid/ready register slice: loads when empty or when downstream drains.
module pipe_stage_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q;
  logic valid_d;
  T     data_q;
  T     data_d;

  // Advance condition and next-state for the slice; data holds when no new item arrives
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // Slice state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mix_pipe_acc.sv
// Three-stage pipelined mixing datapath with valid/ready flow control,
// running XOR accumulator and completed-transaction counter.
module mix_pipe_acc
  import mix_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 38,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned ROT   = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  input_data,
  input  logic             in_mode,
  input  logic             in_acc_en,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] output_data,
  output logic [CNT_W-1:0] txn_count
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    mode_e            mode;
    logic             acc_en;
  } stage_t;

  stage_t           s1_in;
  stage_t           s1_out;
  stage_t           s2_in;
  stage_t           s2_out;
  logic [OUT_W-1:0] s3_in;
  logic             s1_v;
  logic             s2_v;
  logic             s2_rdy;
  logic             s3_rdy;
  logic             load3;
  logic [OUT_W-1:0] t2;
  logic [OUT_W-1:0] acc_eff;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;
  logic [CNT_W-1:0] txn_q;
  logic [CNT_W-1:0] txn_d;

  // Per-stage mixing logic feeding each register slice
  always_comb begin
    s1_in.data   = OUT_W'(mix_s1(64'(input_data), IN_W, OUT_W));
    s1_in.mode   = mode_e'(in_mode);
    s1_in.acc_en = in_acc_en;

    s2_in        = s1_out;
    s2_in.data   = OUT_W'(mix_s2(64'(s1_out.data), OUT_W));

    t2      = OUT_W'(mix_s3(64'(s2_out.data), s2_out.mode, OUT_W, SHIFT, ROT));
    // A clear in the same cycle as a fold wins: the fold sees zero.
    acc_eff = acc_clear ? '0 : acc_q;
    s3_in   = s2_out.acc_en ? (t2 ^ acc_eff) : t2;
    load3   = s2_v && s3_rdy;
  end

  pipe_stage_reg #(.T(stage_t)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_v),
    .out_ready (s2_rdy),
    .out_data  (s1_out)
  );

  pipe_stage_reg #(.T(stage_t)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_v),
    .in_ready  (s2_rdy),
    .in_data   (s2_in),
    .out_valid (s2_v),
    .out_ready (s3_rdy),
    .out_data  (s2_out)
  );

  // mode/acc_en are consumed at the stage-3 load, so only the result is kept there
  pipe_stage_reg #(.T(logic [OUT_W-1:0])) u_stage3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s2_v),
    .in_ready  (s3_rdy),
    .in_data   (s3_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (output_data)
  );

  // Accumulator and transaction counter next-state
  always_comb begin
    acc_d = acc_q;
    if (load3 && s2_out.acc_en) acc_d = s3_in;
    else if (acc_clear)         acc_d = '0;
    txn_d = txn_q;
    if (out_valid && out_ready) txn_d = txn_q + 1'b1;
  end

  // Accumulator and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      txn_q <= '0;
    end else begin
      acc_q <= acc_d;
      txn_q <= txn_d;
    end
  end

  assign txn_count = txn_q;

endmodule

// File: tb/tb_mix_pipe_acc.sv
// Directed scoreboard bench for mix_pipe_acc.
module tb_mix_pipe_acc;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 38;
  localparam int unsigned SHIFT = 7;
  localparam int unsigned ROT   = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [OUT_W-1:0] R0 = 38'h3F800000E1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  input_data = '0;
  logic             in_mode = 1'b0;
  logic             in_acc_en = 1'b0;
  logic             acc_clear = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] output_data;
  logic [CNT_W-1:0] txn_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [OUT_W-1:0] sb[$];
  logic [OUT_W-1:0] m_acc = '0;

  mix_pipe_acc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .ROT   (ROT),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_data  (input_data),
    .in_mode     (in_mode),
    .in_acc_en   (in_acc_en),
    .acc_clear   (acc_clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_data (output_data),
    .txn_count   (txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [OUT_W-1:0] ref_t2(input logic [IN_W-1:0] x, input logic m);
    logic [OUT_W-1:0] a, nx, t0, t1, r;
    logic [IN_W-1:0]  xc;
    xc = ~x;
    a  = OUT_W'(x);
    nx = OUT_W'(xc);
    t0 = a + nx + a;
    t1 = (t0 * ~t0) ^ t0;
    r  = {t1[OUT_W-ROT-1:0], t1[OUT_W-1:OUT_W-ROT]};
    return m ? (t1 + r) : (t1 ^ (t1 >> SHIFT));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // clr: acc_clear will be pulsed in this operand's stage-3 load cycle
  task automatic push(input logic [IN_W-1:0] x, input logic m, input logic ae, input logic clr);
    logic [OUT_W-1:0] r;
    r = ref_t2(x, m);
    if (ae) begin
      r = r ^ (clr ? '0 : m_acc);
      m_acc = r;
    end else if (clr) begin
      m_acc = '0;
    end
    sb.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] x, input logic m, input logic ae, input logic clr);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; input_data = x; in_mode = m; in_acc_en = ae;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push(x, m, ae, clr);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    n_assert++;
    assert (done) else begin
      n_fail++;
      $error("FAIL send_timeout: observed in_ready low for 64 cycles, required acceptance");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
    m_acc = '0;
  endtask

  // Output monitor: every result handshake is compared with the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed output %h, required no output", output_data);
      end
      if (sb.size() > 0) check("result", 64'(output_data), 64'(sb.pop_front()));
    end
  end

  initial begin
    logic [IN_W-1:0] rx[10];
    logic            rm[10];
    logic            ra[10];
    int              c0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(output_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_txn", 64'(txn_count), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single operand latency and value
    send(4'd0, 1'b0, 1'b0, 1'b0);
    check("lat_v0", 64'(out_valid), 64'd0);
    tick();
    check("lat_v1", 64'(out_valid), 64'd0);
    tick();
    check("lat_v2", 64'(out_valid), 64'd1);
    check("lat_data", 64'(output_data), 64'(R0));
    tick();
    check("txn_one", 64'(txn_count), 64'd1);
    drain();

    // Back-to-back accumulate: second fold cancels the first
    send(4'd0, 1'b0, 1'b1, 1'b0);
    send(4'd0, 1'b0, 1'b1, 1'b0);
    drain();

    // Clear coincident with the second operand's fold
    send(4'd0, 1'b0, 1'b1, 1'b0);
    send(4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    check("clr_fold_valid", 64'(out_valid), 64'd1);
    check("clr_fold_data", 64'(output_data), 64'(R0));
    send(4'd0, 1'b0, 1'b1, 1'b0);
    drain();

    // Ten random operands with a five-cycle output stall
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rx[i] = IN_W'($urandom_range(0, 15));
      rm[i] = 1'($urandom_range(0, 1));
      ra[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 3; i++) send(rx[i], rm[i], ra[i], 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; input_data = rx[3]; in_mode = rm[3]; in_acc_en = ra[3];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(output_data), 64'(sb[0]));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 3; i < 10; i++) send(rx[i], rm[i], ra[i], 1'b0);
    drain();
    check("txn_ten", 64'(txn_count), 64'd10);

    // Full-throughput sweep over all operands and both modes
    c0 = 0;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        send(IN_W'(x), 1'(m), 1'b0, 1'b0);
        if (m == 0 && x == 0) c0 = cyc;
      end
    end
    check("sweep_span", 64'(cyc - c0), 64'd31);
    tick();
    tick();
    check("sweep_tail_valid", 64'(out_valid), 64'd1);
    check("sweep_tail_left", 64'(sb.size()), 64'd1);
    drain();

    // Asynchronous reset with three operands in flight
    for (int i = 0; i < 3; i++) send(IN_W'(i + 3), 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_txn", 64'(txn_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_data", 64'(output_data), 64'd0);
    sb.delete();
    m_acc = '0;
    tick();
    rst_n = 1'b1;
    tick();
    send(4'd9, 1'b1, 1'b1, 1'b0);
    check("post_rst_v0", 64'(out_valid), 64'd0);
    tick();
    check("post_rst_v1", 64'(out_valid), 64'd0);
    tick();
    check("post_rst_v2", 64'(out_valid), 64'd1);
    check("post_rst_data", 64'(output_data), 64'(ref_t2(4'd9, 1'b1)));
    drain();
    check("post_rst_txn", 64'(txn_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
